// File: rtl/dsp_result_shaper.sv
// Shapes signed DSP P results (round, shift, saturate/wrap) into a narrow fabric word and
// buffers them in a credit-throttled FIFO, so results are never dropped under backpressure.
module dsp_result_shaper #(
    parameter int unsigned P_W     = 40,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned SHIFT   = 0,
    parameter int unsigned OUT_W   = 18,
    parameter int unsigned SAT     = 1,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [P_W-1:0]         p,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   ovf,
    input  logic                   clr_ovf,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned W  = P_W + 1;

    localparam logic [CW-1:0]    DEPTH_C = DEPTH[CW-1:0];
    localparam logic [W-1:0]     HALF    = ({{(W-1){1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic              accept;
    logic              tag_out;
    logic              push;
    logic              pop;
    logic [CW:0]       outstanding;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     level_q, level_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OUT_W-1:0]  mem_q [DEPTH];
    logic              ovf_q, ovf_d;

    logic signed [W-1:0] ext, rnd, shf;
    logic [W-OUT_W:0]    hi;
    logic                fits;
    logic [OUT_W-1:0]    shaped;

    // Credits cover both results still inside the DSP and results already buffered.
    assign outstanding = {1'b0, inflight_q} + {1'b0, level_q};
    assign issue_ready = !rst && (outstanding < {1'b0, DEPTH_C});
    assign accept      = issue_valid && issue_ready;

    generate
        if (LATENCY == 0) begin : g_lat0
            assign tag_out = accept;
        end else begin : g_tag_pipe
            logic [LATENCY-1:0] tag_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_q <= '0;
                end else begin
                    tag_q[0] <= accept;
                    for (int i = 1; i < LATENCY; i++) begin
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end
            assign tag_out = tag_q[LATENCY-1];
        end
    endgenerate

    // Round half up, arithmetic shift, then check the upper bits are pure sign extension.
    always_comb begin
        ext    = $signed({p[P_W-1], p});
        rnd    = ext + $signed(HALF);
        shf    = rnd >>> SHIFT;
        hi     = shf[W-1:OUT_W-1];
        fits   = (&hi) | ~(|hi);
        shaped = shf[OUT_W-1:0];
        if ((SAT != 0) && !fits) begin
            shaped = shf[W-1] ? OUT_MIN : OUT_MAX;
        end
    end

    assign push = tag_out;
    assign pop  = out_valid && out_ready;

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !tag_out) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && tag_out) begin
            inflight_d = inflight_q - 1'b1;
        end

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        ovf_d = ovf_q;
        if (push && !fits) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked by level_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= shaped;
        end
    end

    assign out_valid = !rst && (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign ovf       = !rst && ovf_q;
    assign level     = rst ? '0 : level_q;

    a_no_write_when_full : assert property (@(posedge clk) disable iff (rst)
        push |-> (level_q < DEPTH_C));

endmodule

// File: tb/tb_dsp_result_shaper.sv
// Bench for dsp_result_shaper: four differently configured instances share one stimulus stream
// and are compared every cycle against a queue-level reference model, plus directed sequences.
module tb_dsp_result_shaper;

    localparam int N = 4;
    localparam int DEPTH = 4;
    localparam int LAT [N] = '{1, 1, 0, 2};
    localparam int SH  [N] = '{0, 4, 0, 0};
    localparam int SA  [N] = '{1, 1, 0, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [39:0] p = '0;

    logic [N-1:0] rdy, vld, ovf;
    logic [17:0]  dat [N];
    logic [2:0]   lvl [N];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dsp_result_shaper #(.LATENCY(1), .SHIFT(0), .SAT(1)) u0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy[0]), .p(p),
        .out_data(dat[0]), .out_valid(vld[0]), .out_ready(out_ready), .ovf(ovf[0]),
        .clr_ovf(clr_ovf), .level(lvl[0]));
    dsp_result_shaper #(.LATENCY(1), .SHIFT(4), .SAT(1)) u1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy[1]), .p(p),
        .out_data(dat[1]), .out_valid(vld[1]), .out_ready(out_ready), .ovf(ovf[1]),
        .clr_ovf(clr_ovf), .level(lvl[1]));
    dsp_result_shaper #(.LATENCY(0), .SHIFT(0), .SAT(0)) u2 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy[2]), .p(p),
        .out_data(dat[2]), .out_valid(vld[2]), .out_ready(out_ready), .ovf(ovf[2]),
        .clr_ovf(clr_ovf), .level(lvl[2]));
    dsp_result_shaper #(.LATENCY(2), .SHIFT(0), .SAT(1)) u3 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy[3]), .p(p),
        .out_data(dat[3]), .out_valid(vld[3]), .out_ready(out_ready), .ovf(ovf[3]),
        .clr_ovf(clr_ovf), .level(lvl[3]));

    task automatic chk(input string name, input int inst, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", name, inst, $time, got, exp);
        end
    endtask

    // Plain integer arithmetic: value = floor((p + half) / 2^sh), then clamp or wrap to 18 bits.
    task automatic shape(input logic [39:0] pv, input int sh, input int sa,
                         output logic [17:0] d, output bit fl);
        longint v;
        v = longint'($signed(pv));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        fl = (v > 131071) || (v < -131072);
        if (sa != 0 && v > 131071) v = 131071;
        if (sa != 0 && v < -131072) v = -131072;
        d = v[17:0];
    endtask

    // Reference model: per instance, a list of due cycles for issued ops and a FIFO queue.
    int          pend_due [N][8];
    int          pend_n   [N];
    logic [17:0] mq       [N][8];
    int          mq_n     [N];
    bit          movf     [N];
    int          cyc = 0;
    bit          rst_prev = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) begin
            pend_n[i] = 0;
            mq_n[i] = 0;
            movf[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic [17:0] d;
            bit fl, acc, wrote, wfl;
            if (rst) begin
                pend_n[i] = 0;
                mq_n[i] = 0;
                movf[i] = 1'b0;
            end else begin
                acc = issue_valid && ((pend_n[i] + mq_n[i]) < DEPTH);
                wrote = 1'b0;
                wfl = 1'b0;
                if (out_ready && mq_n[i] > 0) begin
                    for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
                    mq_n[i]--;
                end
                if (pend_n[i] > 0 && pend_due[i][0] == cyc) begin
                    shape(p, SH[i], SA[i], d, fl);
                    mq[i][mq_n[i]] = d;
                    mq_n[i]++;
                    wrote = 1'b1;
                    wfl = fl;
                    for (int k = 0; k < 7; k++) pend_due[i][k] = pend_due[i][k+1];
                    pend_n[i]--;
                end
                if (acc) begin
                    if (LAT[i] == 0) begin
                        shape(p, SH[i], SA[i], d, fl);
                        mq[i][mq_n[i]] = d;
                        mq_n[i]++;
                        wrote = 1'b1;
                        wfl = fl;
                    end else begin
                        pend_due[i][pend_n[i]] = cyc + LAT[i];
                        pend_n[i]++;
                    end
                end
                if (wrote && wfl) movf[i] = 1'b1;
                else if (clr_ovf) movf[i] = 1'b0;
            end
        end
        rst_prev = rst;
        cyc++;
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            bit ve;
            ve = !rst && (mq_n[i] > 0);
            chk("issue_ready", i, 64'(rdy[i]), 64'(!rst && ((pend_n[i] + mq_n[i]) < DEPTH)));
            chk("out_valid", i, 64'(vld[i]), 64'(ve));
            chk("level", i, 64'(lvl[i]), rst ? 64'd0 : 64'(mq_n[i]));
            chk("ovf", i, 64'(ovf[i]), 64'(!rst && movf[i]));
            if (ve || rst || rst_prev) chk("out_data", i, 64'(dat[i]), ve ? 64'(mq[i][0]) : 64'd0);
        end
    end

    typedef struct {
        logic [39:0] p;
        logic [17:0] d1;
        logic        o1;
        logic [17:0] d2;
        logic        o2;
    } vec_t;

    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [39:0] rand_p();
        logic [63:0] r;
        longint v;
        case ($urandom_range(0, 3))
            0: begin
                r = {$urandom, $urandom};
                return r[39:0];
            end
            1: begin
                v = longint'($urandom_range(0, 1 << 20)) - (longint'(1) << 19);
                return v[39:0];
            end
            2: begin
                v = longint'($urandom_range(0, 1 << 23)) - (longint'(1) << 22);
                return v[39:0];
            end
            default: return ($urandom_range(0, 1) != 0) ? 40'h7FFFFFFFFF : 40'h8000000000;
        endcase
    endfunction

    initial begin
        int acc_cnt;

        tbl[0] = '{40'h0000000018, 18'h00002, 1'b0, 18'h00018, 1'b0};
        tbl[1] = '{40'h0010000000, 18'h1FFFF, 1'b1, 18'h00000, 1'b1};
        tbl[2] = '{40'hFFFFFE0000, 18'h3E000, 1'b0, 18'h20000, 1'b0};
        tbl[3] = '{40'h0000020000, 18'h02000, 1'b0, 18'h20000, 1'b1};
        tbl[4] = '{40'h8000000000, 18'h20000, 1'b1, 18'h00000, 1'b1};
        tbl[5] = '{40'h0000000017, 18'h00001, 1'b0, 18'h00017, 1'b0};
        tbl[6] = '{40'hFFFFFFFFE8, 18'h3FFFF, 1'b0, 18'h3FFE8, 1'b0};
        tbl[7] = '{40'h0000000028, 18'h00003, 1'b0, 18'h00028, 1'b0};
        tbl[8] = '{40'hFFFFFFFFD8, 18'h3FFFE, 1'b0, 18'h3FFD8, 1'b0};

        // Reset, then one op on the LATENCY=1 instance.
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", 0, 64'(vld[0]), 64'd0);
        chk("post_reset_level", 0, 64'(lvl[0]), 64'd0);
        step();
        issue_valid = 1'b1;
        p = 40'h0000000123;
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("single_early_valid", 0, 64'(vld[0]), 64'd0);
        step();
        @(negedge clk);
        chk("single_valid", 0, 64'(vld[0]), 64'd1);
        chk("single_data", 0, 64'(dat[0]), 64'h123);
        chk("single_ovf", 0, 64'(ovf[0]), 64'd0);
        out_ready = 1'b1;
        repeat (4) step();

        // Backpressure: only DEPTH accepts while the consumer is stalled.
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            issue_valid = 1'b1;
            p = rand_p();
            @(negedge clk);
            if (rdy[0]) acc_cnt++;
            step();
        end
        issue_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepts", 0, 64'(acc_cnt), 64'd4);
        chk("bp_level", 0, 64'(lvl[0]), 64'd4);
        chk("bp_ready_low", 0, 64'(rdy[0]), 64'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_still_low", 0, 64'(rdy[0]), 64'd0);
        step();
        @(negedge clk);
        chk("bp_ready_reassert", 0, 64'(rdy[0]), 64'd1);
        repeat (6) step();

        // Shaping table: inst1 is SHIFT=4/SAT=1, inst2 is SHIFT=0/SAT=0.
        for (int e = 0; e < 9; e++) begin
            out_ready = 1'b0;
            clr_ovf = 1'b1;
            step();
            clr_ovf = 1'b0;
            issue_valid = 1'b1;
            p = tbl[e].p;
            step();
            issue_valid = 1'b0;
            step();
            @(negedge clk);
            chk("tbl_valid", 1, 64'(vld[1]), 64'd1);
            chk("tbl_data", 1, 64'(dat[1]), 64'(tbl[e].d1));
            chk("tbl_ovf", 1, 64'(ovf[1]), 64'(tbl[e].o1));
            chk("tbl_data", 2, 64'(dat[2]), 64'(tbl[e].d2));
            chk("tbl_ovf", 2, 64'(ovf[2]), 64'(tbl[e].o2));
            out_ready = 1'b1;
            repeat (3) step();
        end

        // Streaming through the LATENCY=2 instance: p=k arrives two cycles after issue k.
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            issue_valid = (i < 16);
            p = (i >= 2) ? 40'(i - 2) : rand_p();
            @(negedge clk);
            if (i == 2 || i == 19) chk("stream_idle", 3, 64'(vld[3]), 64'd0);
            if (i >= 3 && i < 19) begin
                chk("stream_valid", 3, 64'(vld[3]), 64'd1);
                chk("stream_data", 3, 64'(dat[3]), 64'(i - 3));
            end
            step();
        end
        issue_valid = 1'b0;
        repeat (3) step();

        // Reset with two results in flight and two buffered in the LATENCY=2 instance.
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            issue_valid = 1'b1;
            p = rand_p();
            step();
        end
        issue_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_forced", 3, 64'(rdy[3]), 64'd0);
        step();
        rst = 1'b0;
        p = rand_p();
        @(negedge clk);
        chk("rst_valid", 3, 64'(vld[3]), 64'd0);
        chk("rst_level", 3, 64'(lvl[3]), 64'd0);
        chk("rst_ready_back", 3, 64'(rdy[3]), 64'd1);
        for (int c = 0; c < 2; c++) begin
            step();
            p = rand_p();
            @(negedge clk);
            chk("rst_stale", 3, 64'(vld[3]), 64'd0);
        end
        step();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            p = rand_p();
            step();
        end
        issue_valid = 1'b0;
        rst = 1'b0;
        clr_ovf = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_result_shaper.md
Name: dsp_result_shaper

Overview:
- Sits directly downstream of the efpga_mult*/efpga_macc* DSP cells, on their 40-bit `y`/P output.
- Tracks which DSP cycles carry valid results using a tag pipeline matched to the DSP latency.
- Rounds, shifts and saturates each result to a narrower fabric word, then buffers it in a small FIFO with valid/ready output.
- The DSP cannot stall, so the block throttles operand issue with a credit scheme: results are never dropped under backpressure.

Parameters:
- P_W, 40, DSP result width.
- LATENCY, 1, cycles from operand issue to valid P. Range 0..3: 0 = efpga_mult, 1 = _regi/_rego, 2 = _regio.
- SHIFT, 0, arithmetic right shift applied after rounding. Range 0..P_W-2.
- OUT_W, 18, output width.
- SAT, 1, 1 = signed saturate to OUT_W; 0 = truncate (wrap).
- DEPTH, 4, FIFO entries and total credits. Must be a power of 2, ≥2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  upstream presents operands to the DSP this cycle.
- issue_ready  out  1  credit available; an issue is accepted when issue_valid & issue_ready.
- p  in  P_W  DSP result, signed.
- out_data  out  OUT_W  shaped result at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts; pop on out_valid & out_ready.
- ovf  out  1  sticky: a result was clipped (SAT=1) or wrapped (SAT=0).
- clr_ovf  in  1  clears ovf.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: synchronous, active-high. While rst=1 and on the cycle after:
  - out_valid=0, out_data=0, ovf=0, level=0.
  - Tag pipe cleared; in-flight counter = 0.
  - issue_ready forced 0 while rst=1.
  - Reset mid-operation discards all in-flight and buffered results. P values arriving for pre-reset issues are ignored.
- Credit:
  - outstanding = inflight + level.
  - issue_ready = !rst & (outstanding < DEPTH). Combinational from registers only; no dependency on issue_valid.
  - inflight increments on accept and decrements on tag exit; both in the same cycle leaves it unchanged.
  - Outstanding never exceeds DEPTH, so the FIFO cannot overflow. An assertion checks write-when-full never occurs.
- Tag pipe: a LATENCY-deep shift register of accept bits. tag_out = the accept LATENCY cycles earlier. For LATENCY=0, tag_out = accept (same cycle).
- Shaping (combinational on p, written when tag_out=1):
  - Work in P_W+1 bits, sign-extended.
  - If SHIFT>0, add 2^(SHIFT-1) (round half up toward +inf). Then arithmetic shift right by SHIFT.
  - SAT=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SAT=0: keep the low OUT_W bits.
  - The clip/wrap flag is set if the result is not exactly representable.
- FIFO:
  - Write at the clock edge ending the tag_out cycle.
  - Registered head: out_valid rises the cycle after the write.
  - Issue-to-out_valid latency = LATENCY+1 cycles.
  - Simultaneous push and pop: level unchanged, order preserved. Pop of the last entry with a concurrent push shows the new entry with no bubble.
  - out_data holds its value while out_valid & !out_ready.
  - Pointers wrap modulo DEPTH.
- ovf: set at the write edge of a flagged result. clr_ovf=1 clears it, but a set in the same cycle wins.
- Full throughput: one result per cycle when out_ready is held at 1.

Test Plan:
- Reset, then LATENCY=1: issue one op with p=40'h00000_00123 at t+1 -> out_valid at t+2, out_data=18'h00123, ovf=0.
- Backpressure, DEPTH=4, out_ready=0: issue_valid held high -> exactly 4 accepts, issue_ready low afterwards, level=4. Set out_ready=1 -> 4 results in issue order; issue_ready reasserts the cycle after the first pop.
- SHIFT=4, SAT=1: p=40'h00000_00018 (24) -> out_data=2 (24+8=32, >>4). Then p=40'h00100_00000 -> out_data=18'h1FFFF, ovf=1. Apply clr_ovf -> ovf=0.
- SAT=0, SHIFT=0: p=40'hFF_FFFE_0000 (-131072) -> out_data=18'h20000, ovf=0. Then p=40'h00000_20000 -> out_data=18'h20000, ovf=1.
- Streaming, out_ready=1, LATENCY=2: issue 16 consecutive ops with p=k -> 16 consecutive out_valid cycles carrying 0..15, starting at issue+3, no bubbles.
- rst pulsed with 2 in flight and 2 buffered: out_valid=0 the next cycle, level=0. Stale p values arriving over the following 2 cycles produce no output. issue_ready=1 the cycle after rst drops.
